serial_sub_seq: RTL

//   Bit-serial WIDTH-bit subtractor sequencer: one 1-bit full_sub cell computes

---
 rtl/sub_seq_pkg.sv | 12 +
 rtl/full_sub.sv | 13 +
 rtl/serial_sub_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and defaults for the bit-serial subtractor sequencer.
package sub_seq_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_seq.sv
// Bit-serial WIDTH-bit subtractor: one full_sub cell, one bit per clock, LSB first.
// Start/busy/done handshake; diff/bout/zero held until the next completion.
module serial_sub_seq
  import sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  // Partial difference keeps only the upper WIDTH-1 bits: the newest cell bit
  // is concatenated on the fly, so the full word exists only as w_sd_nxt.
  logic [WIDTH-2:0] r_sd;
  logic             r_brw;
  logic [CNT_W-1:0] r_idx;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_cell_d;
  logic             w_cell_bo;
  logic [WIDTH-1:0] w_sd_nxt;

  full_sub u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_brw),
    .diff (w_cell_d),
    .bout (w_cell_bo)
  );

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_idx == LAST_IDX);
  assign w_sd_nxt = {w_cell_d, r_sd};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE/DONE accept start, RUN ends after the last bit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, serial shift datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sd   <= '0;
      r_brw  <= 1'b0;
      r_idx  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_brw <= bin_init;
      r_idx <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sd  <= w_sd_nxt[WIDTH-1:1];
      r_brw <= w_cell_bo;
      r_idx <= r_idx + CNT_W'(1);
      if (w_last) begin
        r_diff <= w_sd_nxt;
        r_bout <= w_cell_bo;
        r_zero <= (w_sd_nxt == '0);
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;

endmodule
